// File: rtl/uart_rx_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_pkg
//   Shared definitions for the UART receive front end.
//   - Default widths for the prescale/edge counter and the bit counter.
//   - Legal oversampling ratios (8, 16, 32).
//   - Counter state encoding.
//   - majority3: 2-of-3 vote used to turn three mid-bit samples into one bit.
// -----------------------------------------------------------------------------
package uart_rx_pkg;

  localparam int PRESC_W_DEF   = 6;  // holds P-1 for P up to 32
  localparam int BIT_CNT_W_DEF = 4;  // start + 8 data + parity + stop fits

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  // IDLE while the RX FSM holds enable low, COUNT while it is high.
  typedef enum logic {
    CNT_IDLE  = 1'b0,
    CNT_COUNT = 1'b1
  } cnt_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// -----------------------------------------------------------------------------
// uart_rx_edge_bit_counter
//   Oversampling edge counter and bit counter for the UART receiver, plus the
//   prescale latch. The oversampling ratio is captured when enable rises and
//   held for the whole frame; illegal ratios fall back to 8.
//
// Ports
//   CLK       in   oversampling clock
//   RST       in   asynchronous active-low reset
//   enable    in   counter enable from the RX FSM
//   Prescale  in   requested oversampling ratio (8, 16 or 32)
//   edge_cnt  out  edge index within the current bit, 0..P-1
//   bit_cnt   out  completed bits in the current frame, saturating
//   presc     out  latched oversampling ratio P used by the sampler
// -----------------------------------------------------------------------------
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W   = PRESC_W_DEF,
  parameter int BIT_CNT_W = BIT_CNT_W_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 enable,
  input  logic [PRESC_W-1:0]   Prescale,
  output logic [PRESC_W-1:0]   edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic [PRESC_W-1:0]   presc
);

  cnt_state_e           state_q, state_d;
  logic                 start;
  logic [PRESC_W-1:0]   presc_legal;
  logic [PRESC_W-1:0]   presc_eff;
  logic [PRESC_W-1:0]   presc_d;
  logic [PRESC_W-1:0]   edge_d;
  logic [BIT_CNT_W-1:0] bit_d;

  // Map the requested ratio onto a legal one.
  always_comb begin
    presc_legal = PRESC_W'(PRESC_8);
    if (Prescale == PRESC_W'(PRESC_16)) presc_legal = PRESC_W'(PRESC_16);
    if (Prescale == PRESC_W'(PRESC_32)) presc_legal = PRESC_W'(PRESC_32);
  end

  // The first enabled cycle counts with the freshly latched ratio, so the
  // wrap compare must see it before the latch register has updated.
  assign start     = (state_q == CNT_IDLE) && enable;
  assign presc_eff = start ? presc_legal : presc;
  assign presc_d   = presc_eff;

  // NOTE: every signal assigned in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    edge_d  = edge_cnt;
    bit_d   = bit_cnt;

    state_d = enable ? CNT_COUNT : CNT_IDLE;

    unique case (state_d)
      CNT_IDLE: begin
        edge_d = '0;
        bit_d  = '0;
      end
      CNT_COUNT: begin
        if (edge_cnt == presc_eff - PRESC_W'(1)) begin
          edge_d = '0;
          // Saturate so an over-long frame cannot alias back to a small count.
          if (bit_cnt != '1) bit_d = bit_cnt + BIT_CNT_W'(1);
        end else begin
          edge_d = edge_cnt + PRESC_W'(1);
        end
      end
      default: begin
        edge_d = '0;
        bit_d  = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= CNT_IDLE;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      presc    <= PRESC_W'(PRESC_8);
    end else begin
      state_q  <= state_d;
      edge_cnt <= edge_d;
      bit_cnt  <= bit_d;
      presc    <= presc_d;
    end
  end

endmodule

// File: rtl/uart_rx_edge_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_edge_sampler
//   Timing and sampling front end of the UART receiver. Counts oversampling
//   edges and bits while enabled and majority-votes three mid-bit samples of
//   the serial line (edges M-2, M-1 and M, with M = P/2) into one bit.
//
//   Optional build macro RX_SYNC_EN: when defined, RX_IN passes through a
//   2-flop synchronizer (reset value 1) before sampling, adding 2 cycles of
//   pin-to-sampler latency. When undefined, RX_IN is assumed already
//   synchronized upstream and is sampled directly.
//
// Ports
//   CLK          in   oversampling clock
//   RST          in   asynchronous active-low reset
//   RX_IN        in   serial line, idle high
//   Prescale     in   oversampling ratio (8, 16, 32; others treated as 8)
//   enable       in   counter enable from the RX FSM
//   dat_samp_en  in   sampling enable from the RX FSM
//   edge_cnt     out  edge index within the current bit, 0..P-1
//   bit_cnt      out  completed bits in the current frame
//   sampled_bit  out  last majority-voted bit
//   sample_valid out  one-cycle strobe: sampled_bit just updated
// -----------------------------------------------------------------------------
module uart_rx_edge_sampler
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W   = PRESC_W_DEF,
  parameter int BIT_CNT_W = BIT_CNT_W_DEF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RX_IN,
  input  logic [PRESC_W-1:0]   Prescale,
  input  logic                 enable,
  input  logic                 dat_samp_en,
  output logic [PRESC_W-1:0]   edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 sampled_bit,
  output logic                 sample_valid
);

  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] mid;
  logic               rx_line;
  logic               s0, s1;
  logic               at_s0, at_s1, at_vote;

  uart_rx_edge_bit_counter #(
    .PRESC_W   (PRESC_W),
    .BIT_CNT_W (BIT_CNT_W)
  ) u_counter (
    .CLK      (CLK),
    .RST      (RST),
    .enable   (enable),
    .Prescale (Prescale),
    .edge_cnt (edge_cnt),
    .bit_cnt  (bit_cnt),
    .presc    (presc)
  );

`ifdef RX_SYNC_EN
  logic rx_meta, rx_sync;

  // NOTE: synchronizer flops reset to the idle line level so leaving reset
  // never looks like a start-bit falling edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rx_sync <= rx_meta;
    end
  end

  assign rx_line = rx_sync;
`else
  assign rx_line = RX_IN;
`endif

  assign mid = presc >> 1;

  // The vote only needs the edge index to read M; on the clock where enable
  // drops the counter still shows M, so a pending vote completes.
  assign at_s0   = dat_samp_en && enable && (edge_cnt == mid - PRESC_W'(2));
  assign at_s1   = dat_samp_en && enable && (edge_cnt == mid - PRESC_W'(1));
  assign at_vote = dat_samp_en && (edge_cnt == mid);

  // If dat_samp_en dropped across an earlier sample point, the vote uses the
  // stale s0/s1 from a previous bit; the RX FSM tolerates this.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s0           <= 1'b1;
      s1           <= 1'b1;
      sampled_bit  <= 1'b1;
      sample_valid <= 1'b0;
    end else begin
      if (at_s0) s0 <= rx_line;
      if (at_s1) s1 <= rx_line;
      if (at_vote) sampled_bit <= majority3(s0, s1, rx_line);
      sample_valid <= at_vote;
    end
  end

endmodule

// File: tb/tb_uart_rx_edge_sampler.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_edge_sampler
//   Self-checking bench for uart_rx_edge_sampler. Directed sequences and a
//   table of majority-vote vectors, followed by randomized traffic compared
//   every cycle against a frame-level reference model (edge = n mod P,
//   bits = min(n div P, 15), votes from a head count of three samples).
//   Works with or without RX_SYNC_EN defined.
// -----------------------------------------------------------------------------
module tb_uart_rx_edge_sampler;

`ifdef RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       enable;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       sampled_bit;
  logic       sample_valid;

  int checks = 0;
  int errors = 0;

  uart_rx_edge_sampler #(
    .PRESC_W   (6),
    .BIT_CNT_W (4)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .Prescale     (Prescale),
    .enable       (enable),
    .dat_samp_en  (dat_samp_en),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------------------------------------------------------- model
  int m_n;          // enabled clock edges counted in this frame
  int m_p;          // latched oversampling ratio
  bit m_active;
  bit m_s0, m_s1, m_bit, m_valid;
  bit pin_q[$];     // pin history feeding the sampler when synchronized

  function automatic int legal_p(input int v);
    return (v == 8 || v == 16 || v == 32) ? v : 8;
  endfunction

  function automatic int exp_edge();
    return m_active ? (m_n % m_p) : 0;
  endfunction

  function automatic int exp_bits();
    int b;
    b = m_n / m_p;
    if (!m_active) return 0;
    return (b > 15) ? 15 : b;
  endfunction

  task automatic model_reset();
    m_n = 0; m_p = 8; m_active = 0;
    m_s0 = 1; m_s1 = 1; m_bit = 1; m_valid = 0;
    pin_q = {};
    for (int i = 0; i < LAT; i++) pin_q.push_back(1'b1);
  endtask

  // One clock edge of the model, reading the inputs present at that edge.
  task automatic model_step();
    int cur, mid, votes;
    bit rx_eff;
    cur = exp_edge();
    mid = m_p / 2;
    if (LAT == 0) rx_eff = RX_IN;
    else          rx_eff = pin_q[0];
    if (dat_samp_en && cur == mid) begin
      votes   = int'(m_s0) + int'(m_s1) + int'(rx_eff);
      m_bit   = (votes >= 2);
      m_valid = 1;
    end else begin
      m_valid = 0;
    end
    if (dat_samp_en && enable && cur == mid - 2) m_s0 = rx_eff;
    if (dat_samp_en && enable && cur == mid - 1) m_s1 = rx_eff;
    if (LAT > 0) begin
      pin_q.push_back(RX_IN);
      void'(pin_q.pop_front());
    end
    if (!enable) begin
      m_active = 0;
      m_n      = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_p      = legal_p(int'(Prescale));
      m_n      = 1;
    end else begin
      m_n++;
    end
  endtask

  // --------------------------------------------------------------- checks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [11:0] act, exp;
    act = {edge_cnt, bit_cnt, sampled_bit, sample_valid};
    exp = {6'(exp_edge()), 4'(exp_bits()), m_bit, m_valid};
    check("model {edge,bits,bit,valid}", 32'(act), 32'(exp));
  endtask

  // Drive inputs, take one clock, then compare just after the edge.
  task automatic step(input logic en, input logic samp, input logic rx, input logic [5:0] presc);
    enable      = en;
    dat_samp_en = samp;
    RX_IN       = rx;
    Prescale    = presc;
    @(posedge CLK);
    model_step();
    #1;
    compare_model();
  endtask

  // Pin value that should reach sample edge e (pattern bits at edges 6,7,8).
  function automatic logic pin_for(input int e, input logic [2:0] pat);
    case (e)
      6:       return pat[2];
      7:       return pat[1];
      8:       return pat[0];
      default: return 1'b1;
    endcase
  endfunction

  typedef struct {
    logic [2:0] pat;
    logic       exp_bit;
  } vote_vec_t;

  vote_vec_t vv[8];
  logic [5:0] presc_tbl[7];

  initial begin
    bit   valid_seen;
    logic en_r;
    logic vote_res;

    vv[0] = '{3'b010, 1'b0};
    vv[1] = '{3'b101, 1'b1};
    vv[2] = '{3'b000, 1'b0};
    vv[3] = '{3'b111, 1'b1};
    vv[4] = '{3'b110, 1'b1};
    vv[5] = '{3'b011, 1'b1};
    vv[6] = '{3'b001, 1'b0};
    vv[7] = '{3'b100, 1'b0};
    presc_tbl = '{6'd8, 6'd16, 6'd32, 6'd12, 6'd0, 6'd63, 6'd24};

    // ---- reset state
    RST = 1'b0; enable = 1'b0; dat_samp_en = 1'b0; RX_IN = 1'b1; Prescale = 6'd8;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("reset edge_cnt", 32'(edge_cnt), 0);
    check("reset bit_cnt", 32'(bit_cnt), 0);
    check("reset sampled_bit", 32'(sampled_bit), 1);
    check("reset sample_valid", 32'(sample_valid), 0);
    RST = 1'b1;
    step(0, 0, 1, 8);

    // ---- reset mid-count
    for (int i = 0; i < 13; i++) step(1, 0, 1, 8);
    check("pre-reset edge_cnt", 32'(edge_cnt), 5);
    check("pre-reset bit_cnt", 32'(bit_cnt), 1);
    #2 RST = 1'b0;
    #1;
    check("async reset edge_cnt", 32'(edge_cnt), 0);
    check("async reset bit_cnt", 32'(bit_cnt), 0);
    check("async reset sampled_bit", 32'(sampled_bit), 1);
    check("async reset sample_valid", 32'(sample_valid), 0);
    model_reset();
    enable = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b1;
    step(0, 0, 1, 8);

    // ---- count and wrap, P=8, 80 enabled cycles
    for (int i = 0; i < 80; i++) step(1, 0, 1, 8);
    check("wrap80 bit_cnt", 32'(bit_cnt), 10);
    check("wrap80 edge_cnt", 32'(edge_cnt), 0);
    step(0, 0, 1, 8);
    check("disable bit_cnt", 32'(bit_cnt), 0);
    check("disable edge_cnt", 32'(edge_cnt), 0);

    // ---- bit counter saturation
    for (int i = 0; i < 136; i++) step(1, 0, 1, 8);
    check("saturate bit_cnt", 32'(bit_cnt), 15);
    step(0, 0, 1, 8);

    // ---- dat_samp_en gating
    step(0, 0, 0, 16);
    valid_seen = 0;
    for (int i = 0; i < 17; i++) begin
      step(1, 0, 0, 16);
      valid_seen |= sample_valid;
    end
    check("gated sample_valid", 32'(valid_seen), 0);
    check("gated sampled_bit", 32'(sampled_bit), 1);
    step(0, 0, 0, 8);

    // ---- enable drops exactly at edge M: vote still completes
    for (int i = 0; i < 4; i++) step(1, 1, 0, 8);
    check("pending edge_cnt", 32'(edge_cnt), 4);
    step(0, 1, 0, 8);
    check("pending sampled_bit", 32'(sampled_bit), 0);
    check("pending sample_valid", 32'(sample_valid), 1);
    check("pending edge cleared", 32'(edge_cnt), 0);
    step(0, 0, 1, 8);
    check("pending strobe one cycle", 32'(sample_valid), 0);

    // ---- majority vote table, P=16
    foreach (vv[v]) begin
      step(0, 0, 1, 16);
      for (int k = 0; k < 16; k++) begin
        step(1, 1, pin_for(k + LAT, vv[v].pat), 16);
        if (k == 8) check($sformatf("vote %03b bit", vv[v].pat), 32'(sampled_bit), 32'(vv[v].exp_bit));
        if (k >= 7 && k <= 9) check($sformatf("vote %03b valid@%0d", vv[v].pat, k), 32'(sample_valid), 32'(k == 8));
      end
    end
    step(0, 0, 1, 16);

    // ---- prescale latched at enable rise, illegal value -> 8
    step(1, 0, 1, 16);
    for (int i = 0; i < 14; i++) step(1, 0, 1, 32);
    check("latch16 edge15", 32'(edge_cnt), 15);
    step(1, 0, 1, 32);
    check("latch16 wrap edge", 32'(edge_cnt), 0);
    check("latch16 wrap bits", 32'(bit_cnt), 1);
    step(0, 0, 1, 32);
    for (int i = 0; i < 7; i++) step(1, 0, 1, 12);
    check("illegal12 edge7", 32'(edge_cnt), 7);
    step(1, 0, 1, 12);
    check("illegal12 wrap edge", 32'(edge_cnt), 0);
    check("illegal12 wrap bits", 32'(bit_cnt), 1);
    step(0, 0, 1, 16);

    // ---- line falls at edge 6: synchronized build sees it two cycles late
    for (int k = 0; k < 16; k++) begin
      step(1, 1, (k >= 6) ? 1'b0 : 1'b1, 16);
      if (k == 8) vote_res = sampled_bit;
    end
    check("fall@6 vote", 32'(vote_res), (LAT == 0) ? 0 : 1);
    step(0, 0, 1, 16);
    for (int k = 0; k < 16; k++) begin
      step(1, 1, (k >= 6 - LAT) ? 1'b0 : 1'b1, 16);
      if (k == 8) vote_res = sampled_bit;
    end
    check("fall aligned vote", 32'(vote_res), 0);
    step(0, 0, 1, 16);

    // ---- randomized traffic against the model
    en_r = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) en_r = ~en_r;
      step(en_r, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
           presc_tbl[$urandom_range(0, 6)]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
